// File: rtl/uart_tx_framer.sv
// UART transmit framer: a one-byte holding register feeding an
// IDLE/START/DATA/PARITY/STOP shifter. Bits go out LSB first, with optional
// even/odd parity and one or two stop bits. A byte can be buffered while the
// previous frame is still on the line, which gives back-to-back frames.
module uart_tx_framer #(
  parameter int CLK_PER_BIT = 100,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_tx,
  input  logic [7:0] tx_data,
  input  logic       block,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_active
);

  localparam int   CNT_W     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t           state, state_nxt;
  logic             hold_full;
  logic [7:0]       hold_data;
  logic [7:0]       shift_q;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             stop_cnt;
  logic             tx_nxt;
  logic             load;
  logic             accept;
  logic             bit_end;

  // Parity over the byte on the line: even = XOR of data, odd = its inverse.
  function automatic logic par_bit(input logic [7:0] d);
    par_bit = (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  assign accept    = new_tx && !hold_full;
  assign bit_end   = (baud_cnt == CNT_W'(CLK_PER_BIT - 1));
  assign tx_busy   = hold_full;
  assign tx_active = (state != S_IDLE);

  // Next-state, next serial bit and holding-to-shifter transfer.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (hold_full && !block) begin
          load      = 1'b1;
          state_nxt = S_START;
          tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          tx_nxt    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            if (PARITY != 0) begin
              state_nxt = S_PAR;
              tx_nxt    = par_bit(shift_q);
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            tx_nxt = shift_q[bit_idx + 3'd1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end && (stop_cnt == STOP_LAST)) begin
          // A buffered byte starts immediately: no idle gap between frames.
          if (hold_full && !block) begin
            load      = 1'b1;
            state_nxt = S_START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // Control state: FSM, registered line, holding flag and bit timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      hold_full <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      stop_cnt  <= 1'b0;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
      if ((state == S_IDLE) || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
      if ((state == S_DATA) && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if ((state == S_STOP) && bit_end) begin
        stop_cnt <= (stop_cnt == STOP_LAST) ? 1'b0 : (stop_cnt + 1'b1);
      end
    end
  end

  // Byte storage: the holding register and the byte on the line; only the
  // holding flag marks validity, so these need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= tx_data;
    end
    if (load) begin
      shift_q <= hold_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four instances (no parity, even, odd, two stop
// bits) at CLK_PER_BIT=4 share one stimulus. Accepted bytes are queued per
// instance and a line monitor checks every cycle of each frame.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_tx;
  logic [7:0] tx_data;
  logic       block;
  logic [3:0] tx_v, tx_busy_v, tx_active_v;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [4][$];
  bit         mon_busy [4];
  int         gap      [4];
  int         nframes  [4];

  always #5 clk = ~clk;

  uart_tx_framer #(.CLK_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .new_tx(new_tx), .tx_data(tx_data), .block(block),
    .tx_busy(tx_busy_v[0]), .tx(tx_v[0]), .tx_active(tx_active_v[0]));
  uart_tx_framer #(.CLK_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .new_tx(new_tx), .tx_data(tx_data), .block(block),
    .tx_busy(tx_busy_v[1]), .tx(tx_v[1]), .tx_active(tx_active_v[1]));
  uart_tx_framer #(.CLK_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .new_tx(new_tx), .tx_data(tx_data), .block(block),
    .tx_busy(tx_busy_v[2]), .tx(tx_v[2]), .tx_active(tx_active_v[2]));
  uart_tx_framer #(.CLK_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .new_tx(new_tx), .tx_data(tx_data), .block(block),
    .tx_busy(tx_busy_v[3]), .tx(tx_v[3]), .tx_active(tx_active_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int par_of(input int g);
    return (g == 1) ? 1 : (g == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  function automatic int frame_bits(input int g);
    return 10 + ((par_of(g) != 0) ? 1 : 0) + (stop_of(g) - 1);
  endfunction

  // Expected line level for bit position idx of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par == 1) return ^b;
    if (idx == 9 && par == 2) return ~(^b);
    return 1'b1;
  endfunction

  // Line monitor: pops the expected byte at each start bit and compares every
  // cycle of the frame; outside frames tx_active must be low.
  initial begin
    int         cyc   [4];
    int         idle  [4];
    bit         infr  [4];
    logic [7:0] cur   [4];
    for (int g = 0; g < 4; g++) begin
      cyc[g] = 0; idle[g] = 0; infr[g] = 1'b0; cur[g] = 8'h00;
      mon_busy[g] = 1'b0; gap[g] = -1; nframes[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (!rst) begin
          infr[g] = 1'b0; idle[g] = 0; mon_busy[g] = 1'b0;
        end else begin
          if (!infr[g]) begin
            if (tx_v[g] == 1'b0) begin
              if (exp_q[g].size() == 0) begin
                check($sformatf("d%0d_unexpected_frame", g), 32'd1, 32'd0);
                cur[g] = 8'h00;
              end else begin
                cur[g] = exp_q[g].pop_front();
              end
              infr[g] = 1'b1; cyc[g] = 0; gap[g] = idle[g];
              nframes[g]++; mon_busy[g] = 1'b1;
            end else begin
              idle[g]++;
              check($sformatf("d%0d_active_idle", g), 32'(tx_active_v[g]), 32'd0);
            end
          end
          if (infr[g]) begin
            check($sformatf("d%0d_bit%0d_cyc%0d", g, cyc[g] / 4, cyc[g]),
                  32'(tx_v[g]), 32'(exp_bit(cur[g], par_of(g), cyc[g] / 4)));
            check($sformatf("d%0d_active", g), 32'(tx_active_v[g]), 32'd1);
            cyc[g]++;
            if (cyc[g] == frame_bits(g) * 4) begin
              infr[g] = 1'b0; idle[g] = 0; mon_busy[g] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    for (int g = 0; g < 4; g++) exp_q[g].delete();
  endtask

  // Offer one byte; acc states whether the holding register should be free.
  task automatic offer(input logic [7:0] b, input bit acc);
    check($sformatf("busy_before_%0h", b), 32'(tx_busy_v), acc ? 32'h0 : 32'hF);
    new_tx  = 1'b1;
    tx_data = b;
    if (acc) for (int g = 0; g < 4; g++) exp_q[g].push_back(b);
    @(negedge clk);
    new_tx = 1'b0;
    if (acc) check($sformatf("busy_after_%0h", b), 32'(tx_busy_v), 32'hF);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      done = 1'b1;
      for (int g = 0; g < 4; g++)
        if (exp_q[g].size() != 0 || mon_busy[g]) done = 1'b0;
      if (tx_busy_v != 4'h0 || tx_active_v != 4'h0) done = 1'b0;
      if (!done) @(negedge clk);
    end
    check("wait_idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b0; new_tx = 1'b0; tx_data = 8'h00; block = 1'b0;
    tick(3);
    check("reset_tx", 32'(tx_v), 32'hF);
    check("reset_busy", 32'(tx_busy_v), 32'h0);
    check("reset_active", 32'(tx_active_v), 32'h0);
    rst = 1'b1;

    // Single frame right after reset release; busy lasts one cycle.
    offer(8'h68, 1'b1);
    tick(1);
    check("busy_one_cycle", 32'(tx_busy_v), 32'h0);
    wait_idle(300);

    // Buffered byte goes out back to back; byte offered while busy is dropped.
    offer(8'h41, 1'b1);
    tick(8);
    offer(8'h42, 1'b1);
    tick(2);
    offer(8'h43, 1'b0);
    wait_idle(300);
    for (int g = 0; g < 4; g++) check($sformatf("d%0d_b2b_gap", g), 32'(gap[g]), 32'd0);

    // block holds the frame off; release starts it on the next edge.
    block = 1'b1;
    offer(8'h55, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("blocked_tx_%0d", i), 32'(tx_v), 32'hF);
      check($sformatf("blocked_busy_%0d", i), 32'(tx_busy_v), 32'hF);
      tick(1);
    end
    block = 1'b0;
    tick(1);
    check("start_after_unblock", 32'(tx_v), 32'h0);
    wait_idle(300);

    // Reset in the middle of data bit 3 with a second byte buffered.
    offer(8'hA5, 1'b1);
    tick(3);
    offer(8'h3C, 1'b1);
    tick(13);
    check("busy_before_reset", 32'(tx_busy_v), 32'hF);
    #1 rst = 1'b0;
    #2;
    check("async_reset_tx", 32'(tx_v), 32'hF);
    check("async_reset_busy", 32'(tx_busy_v), 32'h0);
    check("async_reset_active", 32'(tx_active_v), 32'h0);
    flush();
    tick(2);
    rst = 1'b1;
    offer(8'h0F, 1'b1);
    wait_idle(300);

    for (int g = 0; g < 4; g++) check($sformatf("d%0d_frame_count", g), 32'(nframes[g]), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
